// File: rtl/hist_pkg.sv
// Shared types, constants and the bin-increment helper for the histogram sequencer.
// Define HIST_SATURATE_EN to make bins stick at all-ones instead of wrapping.
package hist_pkg;

  localparam int NUM_REGS = 64;
  localparam int LANES    = 4;
  localparam int LANE_W   = 16;
  localparam int REG_AW   = 6;
  localparam int LANE_AW  = 2;
  localparam int WORD_W   = LANES * LANE_W;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    DONE
  } hist_state_t;

  // Returns the word with one 16-bit lane incremented; lane n sits at bits [16n+15:16n].
  function automatic logic [WORD_W-1:0] bin_inc(input logic [WORD_W-1:0] i_word,
                                                input logic [LANE_AW-1:0] i_lane);
    logic [WORD_W-1:0] w_word;
    logic [LANE_W-1:0] w_bin;
    w_word = i_word;
    w_bin  = w_word[i_lane*LANE_W +: LANE_W];
`ifdef HIST_SATURATE_EN
    if (w_bin != {LANE_W{1'b1}}) w_bin = w_bin + LANE_W'(1);
`else
    w_bin = w_bin + LANE_W'(1);
`endif
    w_word[i_lane*LANE_W +: LANE_W] = w_bin;
    return w_word;
  endfunction

endpackage

// File: rtl/hist_rmw_pipe.sv
// Two-stage read-modify-write pipe: stage 1 reads/captures the bin word, stage 2
// presents the incremented word for the register-file write port.
module hist_rmw_pipe
  import hist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_accept,
  input  logic [7:0]        i_pix,
  input  logic [WORD_W-1:0] i_rd,
  output logic [REG_AW-1:0] o_a1,
  output logic              o_s2_valid,
  output logic [REG_AW-1:0] o_s2_reg,
  output logic [WORD_W-1:0] o_s2_wd
);

  logic [REG_AW-1:0]  r_a1_hold;
  logic               r_s2_valid;
  logic [REG_AW-1:0]  r_s2_reg;
  logic [WORD_W-1:0]  r_s2_wd;

  logic [REG_AW-1:0]  w_reg;
  logic [LANE_AW-1:0] w_lane;
  logic               w_fwd;
  logic [WORD_W-1:0]  w_word;

  assign w_reg  = i_pix[REG_AW-1:0];
  assign w_lane = i_pix[7:6];

  // A pixel hitting the register stage 2 is writing must build on the new value.
  assign w_fwd  = r_s2_valid && (r_s2_reg == w_reg);
  assign w_word = w_fwd ? r_s2_wd : i_rd;

  // NOTE: the held address comes from a register, not an incomplete combinational assignment, so no latch is inferred.
  assign o_a1 = i_accept ? w_reg : r_a1_hold;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a1_hold  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_reg   <= '0;
      r_s2_wd    <= '0;
    end else begin
      r_s2_valid <= i_accept;
      if (i_accept) begin
        r_a1_hold <= w_reg;
        r_s2_reg  <= w_reg;
        r_s2_wd   <= bin_inc(w_word, w_lane);
      end
    end
  end

  assign o_s2_valid = r_s2_valid;
  assign o_s2_reg   = r_s2_reg;
  assign o_s2_wd    = r_s2_wd;

endmodule

// File: rtl/histogram_accum_ctrl.sv
// Histogram sequencer: clears the 64x4x16 register file, then counts a pixel stream into it.
// Bin saturation instead of wrap is selected with HIST_SATURATE_EN (see hist_pkg::bin_inc).
module histogram_accum_ctrl
  import hist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  input  logic              pix_last,
  output logic              pix_ready,
  output logic              busy,
  output logic              hist_done,
  output logic              rf_we,
  output logic              rf_get8,
  output logic [REG_AW-1:0] rf_a1,
  output logic [REG_AW-1:0] rf_a2,
  output logic [WORD_W-1:0] rf_wd,
  input  logic [WORD_W-1:0] rf_rd
);

  hist_state_t       r_state;
  logic [REG_AW-1:0] r_clr_cnt;
  logic              r_pix_ready;
  logic              r_busy;
  logic              r_hist_done;

  logic              w_accept;
  logic              w_clear;
  logic              w_s2_valid;
  logic [REG_AW-1:0] w_s2_reg;
  logic [WORD_W-1:0] w_s2_wd;

  assign w_accept = pix_valid && r_pix_ready;
  assign w_clear  = (r_state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_clr_cnt   <= '0;
      r_pix_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_hist_done <= 1'b0;
    end else begin
      r_hist_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + REG_AW'(1);
          if (r_clr_cnt == REG_AW'(NUM_REGS - 1)) begin
            r_state     <= ACCUM;
            r_pix_ready <= 1'b1;
          end
        end
        ACCUM: begin
          if (w_accept && pix_last) begin
            r_state     <= DRAIN;
            r_pix_ready <= 1'b0;
          end
        end
        DRAIN: begin
          r_state     <= DONE;
          r_hist_done <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_pix_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  hist_rmw_pipe u_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_accept   (w_accept),
    .i_pix      (pix_data),
    .i_rd       (rf_rd),
    .o_a1       (rf_a1),
    .o_s2_valid (w_s2_valid),
    .o_s2_reg   (w_s2_reg),
    .o_s2_wd    (w_s2_wd)
  );

  // The clear sweep owns the write port; it never overlaps a pipelined increment.
  assign rf_we   = w_clear || w_s2_valid;
  assign rf_a2   = w_clear ? r_clr_cnt : w_s2_reg;
  assign rf_wd   = w_clear ? '0 : w_s2_wd;
  assign rf_get8 = 1'b0;

  assign pix_ready = r_pix_ready;
  assign busy      = r_busy;
  assign hist_done = r_hist_done;

endmodule

// File: tb/tb_histogram_accum_ctrl.sv
// Self-checking bench for histogram_accum_ctrl: models the register file (negedge write,
// combinational read) and predicts every bin from per-bin pixel counts.
`timescale 1ns/1ps
module tb_histogram_accum_ctrl;

`ifdef HIST_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_last;
  logic        pix_ready;
  logic        busy;
  logic        hist_done;
  logic        rf_we;
  logic        rf_get8;
  logic [5:0]  rf_a1;
  logic [5:0]  rf_a2;
  logic [63:0] rf_wd;
  logic [63:0] rf_rd;

  logic [63:0] mem [64];
  logic        bd_en   = 1'b0;
  logic [5:0]  bd_addr = '0;
  logic [63:0] bd_data = '0;
  logic [69:0] wr_q [$];

  int          total [256];
  logic [7:0]  pix_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  histogram_accum_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_last  (pix_last),
    .pix_ready (pix_ready),
    .busy      (busy),
    .hist_done (hist_done),
    .rf_we     (rf_we),
    .rf_get8   (rf_get8),
    .rf_a1     (rf_a1),
    .rf_a2     (rf_a2),
    .rf_wd     (rf_wd),
    .rf_rd     (rf_rd)
  );

  // Register file model: combinational read, write on the falling edge.
  assign rf_rd = mem[rf_a1];
  always @(negedge clk) begin
    if (rf_we) begin
      mem[rf_a2] = rf_wd;
      wr_q.push_back({rf_a2, rf_wd});
    end else if (bd_en) begin
      mem[bd_addr] = bd_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_bin(input int b);
    if (SAT) return (total[b] > 65535) ? 16'hFFFF : 16'(total[b]);
    return 16'(total[b] % 65536);
  endfunction

  function automatic logic [63:0] exp_word(input int r);
    return {exp_bin(192 + r), exp_bin(128 + r), exp_bin(64 + r), exp_bin(r)};
  endfunction

  task automatic backdoor(input logic [5:0] addr, input logic [63:0] data);
    bd_addr = addr;
    bd_data = data;
    bd_en   = 1'b1;
    @(negedge clk);
    #1;
    bd_en = 1'b0;
    tick();
  endtask

  task automatic fill_garbage();
    for (int i = 0; i < 64; i++) backdoor(6'(i), {$urandom, $urandom});
  endtask

  task automatic compare_all(input string tag);
    for (int r = 0; r < 64; r++)
      check($sformatf("%s_reg%0d", tag, r), mem[r], exp_word(r));
  endtask

  task automatic start_and_clear(input string tag, input bit hold_valid);
    int base, n, bad;
    base = wr_q.size();
    if (hold_valid) begin
      pix_valid = 1'b1;
      pix_data  = 8'hAA;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_clr"}, busy, 1);
    n = 0;
    while (!pix_ready && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_clr_latency"}, n, 64);
    check({tag, "_clr_writes"}, wr_q.size() - base, 64);
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (base + i >= wr_q.size() || wr_q[base + i] !== {6'(i), 64'h0}) bad++;
    check({tag, "_clr_seq"}, bad, 0);
    for (int b = 0; b < 256; b++) total[b] = 0;
  endtask

  task automatic drive_frame(input string tag, input int gap_pct, output int first_wait);
    int idx, cyc, a1_bad;
    idx = 0; cyc = 0; a1_bad = 0; first_wait = -1;
    while (idx < pix_q.size() && cyc < 2000) begin
      pix_data  = pix_q[idx];
      pix_last  = (idx == pix_q.size() - 1);
      pix_valid = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
      #1;
      if (pix_valid && pix_ready) begin
        if (rf_a1 !== pix_data[5:0]) a1_bad++;
        if (first_wait < 0) first_wait = cyc;
        total[pix_data]++;
        idx++;
      end
      tick();
      cyc++;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    check({tag, "_accepted"}, idx, pix_q.size());
    check({tag, "_rd_addr"}, a1_bad, 0);
  endtask

  // Called in the cycle right after the last accept.
  task automatic finish_frame(input string tag);
    check({tag, "_drain_done"}, hist_done, 0);
    check({tag, "_drain_we"}, rf_we, 1);
    tick();
    check({tag, "_done_pulse"}, hist_done, 1);
    check({tag, "_done_busy"}, busy, 1);
    tick();
    check({tag, "_done_end"}, hist_done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_we"}, rf_we, 0);
    compare_all(tag);
  endtask

  task automatic random_frame(input int n);
    logic [7:0] v;
    pix_q.delete();
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(2) == 0) v = {2'($urandom_range(3)), pix_q[i-1][5:0]};
      else if ($urandom_range(3) == 0)     v = pix_q.size() > 0 ? pix_q[i-1] : 8'h11;
      else                                 v = 8'($urandom_range(255));
      pix_q.push_back(v);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fw, wr_base;
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0;
    fill_garbage();
    check("rst_ctrl", {pix_ready, busy, hist_done, rf_we, rf_get8}, 0);
    check("rst_a1", rf_a1, 0);
    check("rst_a2", rf_a2, 0);
    check("rst_wd", rf_wd, 0);
    rst = 1'b0;
    tick();

    // Reset in the middle of the clear sweep.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("midclr_addr", rf_a2, 20);
    check("midclr_we", rf_we, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_ctrl", {pix_ready, busy, hist_done, rf_we, rf_get8}, 0);
    check("midrst_addr", {rf_a1, rf_a2}, 0);
    check("midrst_wd", rf_wd, 0);
    tick();
    rst = 1'b0;
    tick();
    check("midrst_idle", {busy, rf_we, pix_ready}, 0);

    // Fresh run: clear over garbage, then three pixels sharing register 5.
    fill_garbage();
    start_and_clear("t_small", 1'b0);
    compare_all("t_clear");
    pix_q = '{8'h05, 8'h45, 8'hC5};
    drive_frame("t_small", 0, fw);
    finish_frame("t_small");
    check("t_small_reg5", mem[5], 64'h0001_0000_0001_0001);

    // Ten back-to-back identical pixels.
    start_and_clear("t_same", 1'b0);
    pix_q.delete();
    repeat (10) pix_q.push_back(8'h3F);
    drive_frame("t_same", 0, fw);
    finish_frame("t_same");
    check("t_same_bin", mem[63][15:0], 10);
    check("t_same_a1_hold", rf_a1, 6'h3F);

    // Pixel offered throughout the clear must be taken on the first ACCUM cycle.
    start_and_clear("t_bp", 1'b1);
    random_frame(40);
    pix_q[0] = 8'hAA;
    drive_frame("t_bp", 0, fw);
    check("t_bp_first_accept", fw, 0);
    finish_frame("t_bp");

    // Randomised frame with idle gaps.
    start_and_clear("t_rand", 1'b0);
    random_frame(300);
    drive_frame("t_rand", 30, fw);
    finish_frame("t_rand");

    // start during ACCUM is ignored; then a preloaded full bin is incremented.
    start_and_clear("t_sat", 1'b0);
    wr_base = wr_q.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t_sat_start_ready", pix_ready, 1);
    check("t_sat_start_busy", busy, 1);
    tick();
    check("t_sat_start_nowr", wr_q.size() - wr_base, 0);
    backdoor(6'd7, 64'h0000_0000_FFFF_0000);
    total[8'h47] = 65535;
    pix_q = '{8'h47};
    drive_frame("t_sat", 0, fw);
    finish_frame("t_sat");
    check("t_sat_bin", mem[7][31:16], SAT ? 16'hFFFF : 16'h0000);

    // Single-pixel frame, then a clean rerun.
    start_and_clear("t_one", 1'b0);
    pix_q = '{8'h00};
    drive_frame("t_one", 0, fw);
    finish_frame("t_one");
    check("t_one_reg0", mem[0], 64'h1);
    start_and_clear("t_rerun", 1'b0);
    random_frame(120);
    drive_frame("t_rerun", 20, fw);
    finish_frame("t_rerun");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/histogram_accum_ctrl.md
Name: histogram_accum_ctrl

Overview:
- Sequencer that builds a 256-bin, 16-bit histogram inside the histogram register file (64 registers x 4 lanes x 16 bits).
- Bin index for pixel p: register = p[5:0], lane = p[7:6]. This is the same mapping the register file's GET8 gather uses.
- Clears all 64 registers, then accepts a pixel stream over a valid/ready handshake and performs pipelined read-modify-write increments through the file's A1/RD read port and A2/WD/WE write port.
- Signals completion after the last pixel's write has landed.

Parameters:
- NUM_REGS, 64, registers in the file; clear sweep length.
- LANE_W, 16, bits per bin counter.

Ports:
- clk  in  1  system clock. The register file writes on negedge; this block runs on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a clear+accumulate run. Honoured only in IDLE.
- pix_valid  in  1  pixel present.
- pix_data  in  8  pixel value (bin index).
- pix_last  in  1  qualifies the final pixel of a frame; sampled with pix_valid.
- pix_ready  out  1  block accepts a pixel this cycle.
- busy  out  1  high in every state except IDLE.
- hist_done  out  1  one-cycle pulse; histogram complete in the file.
- rf_we  out  1  register-file write enable.
- rf_get8  out  1  tied 0; this block never uses gather mode.
- rf_a1  out  6  register-file read address.
- rf_a2  out  6  register-file write address.
- rf_wd  out  64  register-file write data.
- rf_rd  in  64  register-file read data (combinational from rf_a1).

Behaviour:
- Reset (async, rst=1):
  - State to IDLE.
  - pix_ready, busy, hist_done, rf_we, rf_get8 = 0.
  - rf_a1, rf_a2, rf_wd = 0.
  - Pipeline valid bit and clear counter = 0.
  - Register-file contents are not touched; a run aborted by reset leaves a partial histogram, and software must restart.
- FSM states: IDLE, CLEAR, ACCUM, DRAIN, DONE.
- IDLE:
  - start=1 -> CLEAR, clear counter = 0.
  - start in any other state is ignored.
- CLEAR:
  - Each cycle drives rf_we=1, rf_a2=counter, rf_wd=0, then counter+1.
  - After writing address NUM_REGS-1 (64 cycles total) -> ACCUM.
  - pix_ready=0 throughout.
- ACCUM:
  - pix_ready=1; a pixel is accepted when pix_valid & pix_ready.
  - Stage 1 (accept cycle):
    - rf_a1 = pix_data[5:0].
    - At posedge, capture reg = pix_data[5:0], lane = pix_data[7:6] and the 64-bit word.
    - Captured word = rf_wd if stage 2 is valid and its reg equals pix_data[5:0] (forwarding), else rf_rd.
  - Stage 2 (next cycle):
    - rf_we=1, rf_a2=reg.
    - rf_wd = captured word with lane[lane] + 1, modulo 2^LANE_W; other lanes unchanged.
    - Lane n occupies bits [16n+15:16n].
  - Throughput: one pixel per cycle. Back-to-back identical pixels must yield +1 each; forwarding makes this hold.
  - Latency: increment written at negedge of the cycle after acceptance.
  - Accepted pixel with pix_last=1 -> DRAIN; pix_ready drops the following cycle.
- DRAIN: stage 2 completes its write (1 cycle) -> DONE. pix_ready=0.
- DONE: hist_done=1 for exactly one cycle -> IDLE. busy=0 from IDLE onward.
- Idle-cycle outputs: rf_we=0 when stage 2 is empty and not in CLEAR. rf_a1 holds its last value when no pixel is accepted.
- pix_valid with pix_ready=0: no effect. The source must hold data; the block never drops a pixel.

Optional Feature:
- Macro: HIST_SATURATE_EN.
- Defined: bin increment saturates at 16'hFFFF; a saturated lane stays at FFFF.
- Undefined: bin wraps FFFF -> 0000.
- All other behaviour is identical either way.

Decomposition:
- Package hist_pkg holds:
  - state enum hist_state_t (IDLE, CLEAR, ACCUM, DRAIN, DONE).
  - constants NUM_REGS=64, LANES=4, LANE_W=16, REG_AW=6.
  - function bin_inc(word, lane) returning the updated 64-bit word, with saturation under the macro.
- Sub-module hist_rmw_pipe holds stage 1/2 registers, forwarding and write-data generation. The top level keeps the FSM and clear counter.

Test Plan:
- Reset mid-CLEAR (assert rst at clear count 20): all outputs 0 immediately; state IDLE; a fresh start then completes with 64 clear writes, addresses 0..63, data 0.
- Clear then pixels 8'h05, 8'h45, 8'hC5 (pix_last on third): register 5 = {lane3=1, lane2=0, lane1=1, lane0=1}; hist_done pulses 2 cycles after last accept.
- Ten consecutive 8'h3F with pix_valid held high: register 63 lane 0 = 10. Proves forwarding; no lost increments.
- Backpressure: start asserted during ACCUM is ignored; pix_valid high during CLEAR sees pix_ready=0; first pixel is accepted at the first ACCUM cycle, exactly 64 cycles after start.
- Pre-load register 7 lane 1 = FFFF via file backdoor (skip clear by forcing), then pixel 8'h47 -> FFFF with HIST_SATURATE_EN, 0000 without.
- pix_last on the first pixel (8'h00): register 0 lane 0 = 1, hist_done pulses, busy low the cycle after; second start reruns cleanly.
